mem_port_arbiter: RTL and testbench

Two-requester arbiter for the processor's single-ported 24-bit × 2K-word memory. Port 0 is the processor core (memread/memwrite path); port 1 is the program loader / DMA path. Each cycle it issues at most one access, alternating round-robin under contention. It tags each read and routes the returned data, after the memory's fixed read latency, back to the requester that issued it.

---
 rtl/mem_port_arbiter.sv | 86 ++++++++
 tb/tb_mem_port_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port round-robin arbiter for a single-ported memory
// Tags each read so the returned data is qualified to the port that issued it.
module mem_port_arbiter #(
  parameter int DATA_W   = 24,
  parameter int ADDR_W   = 11,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              stall0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic                last_gnt_q, last_gnt_d;
  logic [READ_LAT-1:0] tag_v_q, tag_v_d;
  logic [READ_LAT-1:0] tag_p_q, tag_p_d;
  logic                contend;
  logic                issue_rd;

  // last_gnt_q names the port that won the previous contention; the other one wins next.
  assign contend = req0 & req1;
  assign gnt0    = ~reset & req0 & (~req1 | last_gnt_q);
  assign gnt1    = ~reset & req1 & (~req0 | ~last_gnt_q);
  assign stall0  = req0 & ~gnt0;

  assign mem_en    = gnt0 | gnt1;
  assign mem_we    = gnt1 ? we1 : (gnt0 & we0);
  assign mem_addr  = gnt1 ? addr1 : addr0;
  assign mem_wdata = gnt1 ? wdata1 : wdata0;
  assign issue_rd  = mem_en & ~mem_we;

  assign rvalid0 = tag_v_q[READ_LAT-1] & ~tag_p_q[READ_LAT-1];
  assign rvalid1 = tag_v_q[READ_LAT-1] &  tag_p_q[READ_LAT-1];
  assign rdata0  = mem_rdata;
  assign rdata1  = mem_rdata;

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (contend) begin
      last_gnt_d = gnt1;
    end
  end

  // Writes enter the pipe as invalid tags so read returns stay aligned with mem_rdata.
  always_comb begin
    tag_v_d    = '0;
    tag_p_d    = '0;
    tag_v_d[0] = issue_rd;
    tag_p_d[0] = gnt1;
    for (int i = 1; i < READ_LAT; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_p_d[i] = tag_p_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_q <= 1'b1;
      tag_v_q    <= '0;
      tag_p_q    <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      tag_v_q    <= tag_v_d;
      tag_p_q    <= tag_p_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int DATA_W   = 24;
  localparam int ADDR_W   = 11;
  localparam int READ_LAT = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0, we0, req1, we1;
  logic [ADDR_W-1:0] addr0, addr1, mem_addr;
  logic [DATA_W-1:0] wdata0, wdata1, mem_wdata, mem_rdata, rdata0, rdata1;
  logic              gnt0, gnt1, stall0, rvalid0, rvalid1, mem_en, mem_we;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .stall0(stall0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  function automatic logic [DATA_W-1:0] init_val(input int i);
    if (i == 5) return 24'hABCDEF;
    return DATA_W'((i * 40503) ^ 24'h5A5A5A);
  endfunction

  // Behavioural single-ported memory with a fixed read latency.
  logic [DATA_W-1:0] mem [0:2047];
  logic [DATA_W-1:0] rd_pipe [READ_LAT];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < 2048; i++) mem[i] <= init_val(i);
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    rd_pipe[0] <= mem[mem_addr];
    for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[READ_LAT-1];

  // Reference model state: memory contents in grant order plus expected read returns.
  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
  } exp_t;
  logic [DATA_W-1:0] ref_mem [0:2047];
  exp_t q0[$];
  exp_t q1[$];
  int   last_win = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      while (q0.size() > 0 && q0[0].due < cyc) void'(q0.pop_front());
      while (q1.size() > 0 && q1[0].due < cyc) void'(q1.pop_front());
      if (q0.size() > 0 && q0[0].due == cyc) begin
        chk("rvalid0", rvalid0, 1);
        chk("rdata0", rdata0, q0.pop_front().data);
      end else begin
        chk("rvalid0_idle", rvalid0, 0);
      end
      if (q1.size() > 0 && q1[0].due == cyc) begin
        chk("rvalid1", rvalid1, 1);
        chk("rdata1", rdata1, q1.pop_front().data);
      end else begin
        chk("rvalid1_idle", rvalid1, 0);
      end
    end
  end

  task automatic step(input logic rst,
                      input logic r0, input logic w0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                      input logic r1, input logic w1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                      output int win);
    reset = rst;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    @(negedge clk);
    if (rst)           win = -1;
    else if (r0 && r1) win = 1 - last_win;
    else if (r0)       win = 0;
    else if (r1)       win = 1;
    else               win = -1;
    chk("gnt0", gnt0, win == 0);
    chk("gnt1", gnt1, win == 1);
    chk("mem_en", mem_en, win >= 0);
    chk("stall0", stall0, r0 && win != 0);
    if (win < 0) begin
      chk("mem_we_idle", mem_we, 0);
    end else begin
      chk("mem_we", mem_we, (win == 1) ? w1 : w0);
      chk("mem_addr", mem_addr, (win == 1) ? a1 : a0);
      if ((win == 1) ? w1 : w0) chk("mem_wdata", mem_wdata, (win == 1) ? d1 : d0);
    end
    if (rst) begin
      last_win = 1;
      q0.delete();
      q1.delete();
    end else begin
      if (r0 && r1) last_win = win;
      if (win == 0) begin
        if (w0) ref_mem[a0] = d0;
        else    q0.push_back('{cyc + READ_LAT, ref_mem[a0]});
      end else if (win == 1) begin
        if (w1) ref_mem[a1] = d1;
        else    q1.push_back('{cyc + READ_LAT, ref_mem[a1]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    int w;
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, 0, '0, '0, w);
  endtask

  task automatic do_reset(input int n);
    int w;
    for (int i = 0; i < n; i++) step(1, 0, 0, '0, '0, 0, 0, '0, '0, w);
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    logic [2:0] lo;
    lo = 3'($urandom_range(0, 7));
    return ($urandom_range(0, 1) == 1) ? {8'hFF, lo} : {8'h00, lo};
  endfunction

  initial begin
    int w;
    logic p0, p1, pw0, pw1, rst;
    logic [ADDR_W-1:0] pa0, pa1;
    logic [DATA_W-1:0] pd0, pd1;
    for (int i = 0; i < 2048; i++) ref_mem[i] = init_val(i);

    do_reset(2);
    idle(1);
    step(0, 1, 0, 11'h005, '0, 0, 0, '0, '0, w);
    idle(READ_LAT + 1);

    do_reset(1);
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 11'(16'h020 + i), '0, 1, 0, 11'(16'h030 + i), '0, w);
    idle(READ_LAT + 1);

    step(0, 0, 0, '0, '0, 1, 1, 11'h7FF, 24'h123456, w);
    step(0, 1, 0, 11'h7FF, '0, 0, 0, '0, '0, w);
    idle(READ_LAT + 1);

    for (int i = 0; i < 3; i++) step(0, 1, 0, 11'(16'h010 + i), '0, 0, 0, '0, '0, w);
    idle(READ_LAT + 1);

    step(0, 1, 0, 11'h004, '0, 0, 0, '0, '0, w);
    do_reset(1);
    idle(READ_LAT + 2);
    step(0, 1, 0, 11'h001, '0, 1, 0, 11'h002, '0, w);
    idle(READ_LAT + 1);

    do_reset(1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, '0, '0, 1, 0, 11'(16'h040 + i), '0, w);
    step(0, 1, 0, 11'h050, '0, 1, 0, 11'h051, '0, w);
    step(0, 0, 0, '0, '0, 1, 0, 11'h051, '0, w);
    idle(READ_LAT + 1);

    p0 = 0; p1 = 0; pw0 = 0; pw1 = 0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int c = 0; c < 1500; c++) begin
      if (!p0 && $urandom_range(0, 9) < 6) begin
        p0 = 1; pw0 = ($urandom_range(0, 2) == 0); pa0 = rand_addr(); pd0 = DATA_W'($urandom);
      end
      if (!p1 && $urandom_range(0, 9) < 6) begin
        p1 = 1; pw1 = ($urandom_range(0, 2) == 0); pa1 = rand_addr(); pd1 = DATA_W'($urandom);
      end
      rst = ($urandom_range(0, 199) == 0);
      step(rst, p0, pw0, pa0, pd0, p1, pw1, pa1, pd1, w);
      if (w == 0) p0 = 0;
      if (w == 1) p1 = 1'b0;
    end
    idle(READ_LAT + 3);
    chk("scoreboard_drained", q0.size() + q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
